// File: rtl/key_schedule_ctrl.sv
// rtl/key_schedule_ctrl.sv - AES-128/192/256 key expansion sequencer and round-key server
//
// Expands one 32-bit schedule word per clock into internal storage, then answers
// round-key requests with {w[4r], w[4r+1], w[4r+2], w[4r+3]}. The SubWord S-box bank
// is external and combinational: sub_word_i must equal SubWord(sub_word_o) in the same cycle.
//
// Optional build macro: KEYSCHED_ZEROIZE_EN (adds zeroize port and WIPE state).
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   key_valid/key_ready key load handshake; key_len 00=128 01=192 10=256 11=illegal
//   key[255:0]          key, word0 in key[255:224]
//   sub_word_o/i        shared SubWord port (out to S-box bank, back same cycle)
//   busy, done, nr      expansion in progress, completion pulse, round count of loaded key
//   rk_req, rk_idx      round-key request and round index
//   rk_valid, rk        round-key pulse and 128-bit round key
//   err                 pulse on illegal key_len or rk_idx > nr
//   zeroize             storage wipe request (KEYSCHED_ZEROIZE_EN only)

module key_schedule_ctrl #(
   parameter int MAX_WORDS = 60,
   parameter int WORD_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              key_valid,
   output logic              key_ready,
   input  logic [1:0]        key_len,
   input  logic [255:0]      key,
   output logic [WORD_W-1:0] sub_word_o,
   input  logic [WORD_W-1:0] sub_word_i,
   output logic              busy,
   output logic              done,
   output logic [3:0]        nr,
   input  logic              rk_req,
   input  logic [3:0]        rk_idx,
   output logic              rk_valid,
   output logic [127:0]      rk,
`ifdef KEYSCHED_ZEROIZE_EN
   input  logic              zeroize,
`endif
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXPAND = 2'd1,
      S_READY  = 2'd2
`ifdef KEYSCHED_ZEROIZE_EN
      , S_WIPE = 2'd3
`endif
   } state_t;

   state_t state_q, state_d;

   logic [WORD_W-1:0] w_mem [MAX_WORDS];

   logic [5:0]  widx;      // index of the word written this cycle
   logic [3:0]  jcnt;      // widx mod Nk, kept as a wrapping counter
   logic [3:0]  nk_q;
   logic [3:0]  nr_q;
   logic [5:0]  last_q;    // index of the final schedule word
   logic [7:0]  rcon_q;
   logic [7:0]  rcon_next;

   logic [3:0]  nk_new, nr_new;
   logic [5:0]  last_new;

   logic        zero_req;
   logic        accept, load_ok, load_bad, rk_take;
   logic [5:0]  rk_base;

   logic [WORD_W-1:0] prev_w, old_w, temp_w, new_w;

`ifdef KEYSCHED_ZEROIZE_EN
   logic [3:0]  wipe_cnt;
   assign zero_req = zeroize;
`else
   assign zero_req = 1'b0;
`endif

   // Handshake and request qualification
   assign key_ready = rst_n & ~zero_req & ((state_q == S_IDLE) | (state_q == S_READY));
   assign accept    = key_valid & key_ready;
   assign load_ok   = accept & (key_len != 2'b11);
   assign load_bad  = accept & (key_len == 2'b11);
   // A key load in the same cycle takes priority and drops the round-key request.
   assign rk_take   = (state_q == S_READY) & rk_req & ~accept & ~zero_req;
   assign rk_base   = {rk_idx, 2'b00};

`ifdef KEYSCHED_ZEROIZE_EN
   assign busy = (state_q == S_EXPAND) | (state_q == S_WIPE);
`else
   assign busy = (state_q == S_EXPAND);
`endif

   always_comb begin
      nk_new   = 4'd4;
      nr_new   = 4'd10;
      last_new = 6'd43;
      case (key_len)
         2'b01: begin nk_new = 4'd6; nr_new = 4'd12; last_new = 6'd51; end
         2'b10: begin nk_new = 4'd8; nr_new = 4'd14; last_new = 6'd59; end
         default: ;
      endcase
   end

   assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   // Expansion datapath: w[i] = w[i-Nk] ^ temp, prev = w[i-1]
   assign prev_w = w_mem[widx - 6'd1];
   assign old_w  = w_mem[widx - {2'b00, nk_q}];

   // The S-box request path is kept separate from the result path so the
   // external combinational loop through the S-box bank stays acyclic.
   always_comb begin
      sub_word_o = prev_w;
      if (jcnt == 4'd0)
         sub_word_o = {prev_w[23:0], prev_w[31:24]};
   end

   always_comb begin
      temp_w = prev_w;
      if (jcnt == 4'd0)
         temp_w = sub_word_i ^ {rcon_q, 24'h000000};
      else if ((nk_q == 4'd8) && (jcnt == 4'd4))
         temp_w = sub_word_i;
      new_w = old_w ^ temp_w;
   end

   // FSM
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_READY: if (load_ok) state_d = S_EXPAND;
         S_EXPAND:        if (widx == last_q) state_d = S_READY;
`ifdef KEYSCHED_ZEROIZE_EN
         S_WIPE:          if (wipe_cnt == 4'd14) state_d = S_IDLE;
`endif
         default:         state_d = S_IDLE;
      endcase
`ifdef KEYSCHED_ZEROIZE_EN
      if (zero_req) state_d = S_WIPE;
`endif
   end

   // Control registers and outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         done     <= 1'b0;
         rk_valid <= 1'b0;
         err      <= 1'b0;
         nr       <= 4'd0;
         rk       <= '0;
         widx     <= 6'd0;
         jcnt     <= 4'd0;
         nk_q     <= 4'd0;
         nr_q     <= 4'd0;
         last_q   <= 6'd0;
         rcon_q   <= 8'd0;
`ifdef KEYSCHED_ZEROIZE_EN
         wipe_cnt <= 4'd0;
`endif
      end else begin
         done     <= 1'b0;
         rk_valid <= 1'b0;
         err      <= 1'b0;
         if (zero_req) begin
            rk <= '0;
            nr <= 4'd0;
`ifdef KEYSCHED_ZEROIZE_EN
            wipe_cnt <= 4'd0;
`endif
         end else begin
            case (state_q)
               S_IDLE, S_READY: begin
                  if (load_ok) begin
                     nk_q   <= nk_new;
                     nr_q   <= nr_new;
                     last_q <= last_new;
                     widx   <= {2'b00, nk_new};
                     jcnt   <= 4'd0;
                     rcon_q <= 8'h01;
                     nr     <= 4'd0;
                  end else if (load_bad) begin
                     err <= 1'b1;
                  end else if (rk_take) begin
                     if (rk_idx <= nr) begin
                        rk       <= {w_mem[rk_base], w_mem[rk_base + 6'd1],
                                     w_mem[rk_base + 6'd2], w_mem[rk_base + 6'd3]};
                        rk_valid <= 1'b1;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               S_EXPAND: begin
                  widx <= widx + 6'd1;
                  jcnt <= (jcnt == nk_q - 4'd1) ? 4'd0 : jcnt + 4'd1;
                  if (jcnt == 4'd0) rcon_q <= rcon_next;
                  if (widx == last_q) begin
                     done <= 1'b1;
                     nr   <= nr_q;
                  end
               end
`ifdef KEYSCHED_ZEROIZE_EN
               S_WIPE: wipe_cnt <= wipe_cnt + 4'd1;
`endif
               default: ;
            endcase
         end
      end
   end

   // Word storage; deliberately not reset
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (load_ok) begin
            for (int n = 0; n < 8; n++)
               if (n < int'(nk_new)) w_mem[n] <= key[255-32*n -: 32];
         end else if (state_q == S_EXPAND) begin
            w_mem[widx] <= new_w;
         end
`ifdef KEYSCHED_ZEROIZE_EN
         else if (state_q == S_WIPE && !zero_req) begin
            for (int n = 0; n < 4; n++)
               w_mem[{wipe_cnt, 2'b00} + 6'(n)] <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb/tb_key_schedule_ctrl.sv - scoreboard bench for key_schedule_ctrl

module tb_key_schedule_ctrl;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         key_valid;
   logic         key_ready;
   logic [1:0]   key_len;
   logic [255:0] key;
   logic [31:0]  sub_word_o;
   logic [31:0]  sub_word_i;
   logic         busy;
   logic         done;
   logic [3:0]   nr;
   logic         rk_req;
   logic [3:0]   rk_idx;
   logic         rk_valid;
   logic [127:0] rk;
   logic         err;
`ifdef KEYSCHED_ZEROIZE_EN
   logic         zeroize;
`endif

   key_schedule_ctrl dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
      .key_len(key_len), .key(key), .sub_word_o(sub_word_o), .sub_word_i(sub_word_i),
      .busy(busy), .done(done), .nr(nr), .rk_req(rk_req), .rk_idx(rk_idx),
      .rk_valid(rk_valid), .rk(rk),
`ifdef KEYSCHED_ZEROIZE_EN
      .zeroize(zeroize),
`endif
      .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // AES S-box built from GF(2^8) inverse + affine map
   logic [7:0] sbox [256];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa;
      p = 8'h00; aa = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   assign sub_word_i = {sbox[sub_word_o[31:24]], sbox[sub_word_o[23:16]],
                        sbox[sub_word_o[15:8]],  sbox[sub_word_o[7:0]]};

   function automatic logic [31:0] subw(input logic [31:0] x);
      return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
   endfunction

   function automatic logic [7:0] rcon_of(input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int m = 1; m < n; m++) r = gf_mul(r, 8'h02);
      return r;
   endfunction

   // Reference schedule (FIPS-197 form)
   logic [31:0] mw [60];

   task automatic model_expand(input logic [255:0] k, input int nk_i, input int nr_i);
      logic [31:0] t;
      for (int i = 0; i < nk_i; i++) mw[i] = k[255-32*i -: 32];
      for (int i = nk_i; i < 4*(nr_i+1); i++) begin
         t = mw[i-1];
         if (i % nk_i == 0)
            t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk_i), 24'h0};
         else if (nk_i > 6 && i % nk_i == 4)
            t = subw(t);
         mw[i] = mw[i-nk_i] ^ t;
      end
   endtask

   // Scoreboard
   typedef struct {
      logic [2:0]   kind;   // {done, rk_valid, err}
      logic [127:0] data;
      int           cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && (done || rk_valid || err)) begin
         if (sb.size() == 0) begin
            chk("spurious_event", {125'b0, done, rk_valid, err}, 128'b0);
         end else begin
            mon_e = sb.pop_front();
            chk("event_kind", {125'b0, done, rk_valid, err}, {125'b0, mon_e.kind});
            chk("event_cycle", 128'(cyc), 128'(mon_e.cyc));
            if (done) chk("done_nr", {124'b0, nr}, mon_e.data);
            else      chk(rk_valid ? "rk_value" : "err_rk_hold", rk, mon_e.data);
         end
      end
   end

   // Model state
   bit           m_loaded = 0;
   int           m_acc = 0;
   int           m_w = 0;
   int           m_nr = 0;
   logic [127:0] m_rk = '0;

   function automatic bit m_ready(input int c);
      return m_loaded && (c >= m_acc + m_w);
   endfunction

   function automatic logic [255:0] rand256();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic push(input logic [2:0] kind, input logic [127:0] data, input int c);
      exp_t e;
      e.kind = kind; e.data = data; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic load(input logic [255:0] k, input logic [1:0] len,
                       input bit with_rk, input logic [3:0] idx);
      int c, nk_i, nr_i;
      bit exp_kr;
      @(negedge clk);
      c = cyc;
      key_valid = 1'b1; key = k; key_len = len; rk_req = with_rk; rk_idx = idx;
      #1;
      exp_kr = !m_loaded || m_ready(c);
      chk("key_ready", {127'b0, key_ready}, {127'b0, exp_kr});
      if (exp_kr) begin
         if (len == 2'b11) begin
            push(3'b001, m_rk, c + 1);
         end else begin
            nk_i = (len == 2'b00) ? 4 : (len == 2'b01) ? 6 : 8;
            nr_i = nk_i + 6;
            model_expand(k, nk_i, nr_i);
            m_loaded = 1; m_acc = c + 1; m_nr = nr_i; m_w = 4*(nr_i+1) - nk_i;
            push(3'b100, 128'(nr_i), c + 1 + m_w);
         end
      end
      @(posedge clk); #1;
      key_valid = 1'b0; rk_req = 1'b0;
   endtask

   task automatic rk_request(input logic [3:0] idx);
      int c, b;
      @(negedge clk);
      c = cyc;
      rk_req = 1'b1; rk_idx = idx;
      if (m_ready(c)) begin
         if (int'(idx) <= m_nr) begin
            b = 4 * int'(idx);
            m_rk = {mw[b], mw[b+1], mw[b+2], mw[b+3]};
            push(3'b010, m_rk, c + 1);
         end else begin
            push(3'b001, m_rk, c + 1);
         end
      end
      @(posedge clk); #1;
      rk_req = 1'b0;
   endtask

   task automatic rk_known(input logic [3:0] idx, input logic [127:0] val);
      @(negedge clk);
      rk_req = 1'b1; rk_idx = idx;
      m_rk = val;
      push(3'b010, val, cyc + 1);
      @(posedge clk); #1;
      rk_req = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain_pending", 128'(sb.size()), 128'b0);
      sb.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      sb.delete();
      m_loaded = 0; m_rk = '0;
      #1;
      chk("rst_busy", {127'b0, busy}, 128'b0);
      chk("rst_nr", {124'b0, nr}, 128'b0);
      chk("rst_key_ready", {127'b0, key_ready}, 128'b1);
      chk("rst_flags", {125'b0, done, rk_valid, err}, 128'b0);
      chk("rst_rk", rk, 128'b0);
   endtask

   localparam logic [127:0] K128  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
   localparam logic [191:0] K192  = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
   localparam logic [255:0] K256  = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

   logic [255:0] rk_tmp;
   logic [1:0]   len_r;

   initial begin
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv, s;
         inv = 8'h00;
         for (int b = 1; b < 256; b++)
            if (gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox[a] = s;
      end

      rst_n = 1'b0; key_valid = 1'b0; key_len = 2'b00; key = '0; rk_req = 1'b0; rk_idx = 4'd0;
`ifdef KEYSCHED_ZEROIZE_EN
      zeroize = 1'b0;
`endif
      repeat (3) @(posedge clk);
      do_reset();

      // rk_req with nothing loaded is ignored
      rk_request(4'd0);

      // AES-128 reference vector; low key bits must be ignored
      rk_tmp = rand256();
      load({K128, rk_tmp[127:0]}, 2'b00, 0, 4'd0);
      chk("exp_busy", {127'b0, busy}, 128'b1);
      chk("exp_nr", {124'b0, nr}, 128'b0);
      rk_request(4'd2);
      load(rand256(), 2'b10, 0, 4'd0);
      drain(100);
      chk("nr128", {124'b0, nr}, 128'd10);
      chk("idle_busy", {127'b0, busy}, 128'b0);
      rk_known(4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
      rk_known(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
      rk_request(4'd0);
      rk_request(4'd11);
      drain(10);

      // AES-192
      rk_tmp = rand256();
      load({K192, rk_tmp[63:0]}, 2'b01, 0, 4'd0);
      drain(100);
      chk("nr192", {124'b0, nr}, 128'd12);
      rk_known(4'd12, 128'he98ba06f_448c773c_8ecc7204_01002202);
      rk_request(4'd5);
      rk_request(4'd13);
      drain(10);

      // AES-256
      load(K256, 2'b10, 0, 4'd0);
      drain(100);
      chk("nr256", {124'b0, nr}, 128'd14);
      rk_known(4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e);
      rk_request(4'd15);
      drain(10);

      // Illegal key length in READY: err only, schedule still served
      load(rand256(), 2'b11, 0, 4'd0);
      drain(10);
      chk("bad_len_busy", {127'b0, busy}, 128'b0);
      chk("bad_len_nr", {124'b0, nr}, 128'd14);
      rk_known(4'd14, 128'hfe4890d1_e6188d0b_046df344_706c631e);
      drain(10);

      // Key load and rk_req in the same READY cycle: load wins
      load({K128, 128'h0}, 2'b00, 1, 4'd4);
      drain(100);
      rk_known(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
      drain(10);

      // Randomized keys and request bursts
      for (int it = 0; it < 10; it++) begin
         len_r = 2'($urandom_range(0, 3));
         load(rand256(), len_r, 0, 4'd0);
         drain(100);
         for (int q = 0; q < int'($urandom_range(3, 8)); q++) begin
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
            rk_request(4'($urandom_range(0, 15)));
         end
         drain(20);
      end

      // Reset partway through an AES-256 expansion
      load(K256, 2'b10, 0, 4'd0);
      repeat (18) @(negedge clk);
      chk("pre_reset_busy", {127'b0, busy}, 128'b1);
      do_reset();
      rk_request(4'd0);
      rk_request(4'd14);
      repeat (3) @(negedge clk);
      drain(5);

`ifdef KEYSCHED_ZEROIZE_EN
      load(K256, 2'b10, 0, 4'd0);
      drain(100);
      @(negedge clk);
      zeroize = 1'b1;
      @(posedge clk); #1;
      zeroize = 1'b0;
      m_loaded = 0; m_rk = '0;
      for (int n = 0; n < 15; n++) begin
         chk("wipe_busy", {127'b0, busy}, 128'b1);
         @(posedge clk); #1;
      end
      chk("wipe_end_busy", {127'b0, busy}, 128'b0);
      chk("wipe_key_ready", {127'b0, key_ready}, 128'b1);
      chk("wipe_nr", {124'b0, nr}, 128'b0);
      chk("wipe_rk", rk, 128'b0);
      load({K128, 128'h0}, 2'b00, 0, 4'd0);
      drain(100);
      rk_known(4'd1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605);
      rk_known(4'd10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);
      drain(10);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
